tpu_act_stream_buffer: RTL and testbench
========================================

// Module: tpu_act_stream_buffer
// PURPOSE
//  Multi-bank activation store feeding the systolic array rows with strided, back-pressured streams.
//  NUM_BANKS banks rotate as a ring: one read (stream) bank, the next one fill (write) bank.
//  Sits between the DMA/load path and the array input; successor to the two-bank ping-pong buffer.
//  Adds base/stride addressing, ready/valid output, deferred bank swap and an optional row skew.
// PARAMETERS
//  ARRAY_SIZE  8    lanes per vector (array rows)
//  ACT_BITS    16   bits per activation lane
//  DEPTH       256  vectors per bank, power of two
//  NUM_BANKS   2    ring bank count, >=2
//  ADDR_WIDTH  16   external write address width
// PORTS
//  clk            in   1                      clock
//  rst_n          in   1                      async active-low reset
//  swap_banks     in   1                      pulse: advance ring (rd_bank+1)
//  wr_en          in   1                      write vector to fill bank
//  wr_addr        in   ADDR_WIDTH             vector index in fill bank
//  wr_data        in   ARRAY_SIZE*ACT_BITS    vector to write
//  wr_err         out  1                      pulse: wr_addr >= DEPTH, write dropped
//  stream_start   in   1                      pulse: launch stream (IDLE only)
//  stream_base    in   clog2(DEPTH)           first vector index
//  stream_stride  in   clog2(DEPTH)           index increment per beat
//  stream_count   in   clog2(DEPTH)+1         beats, 0..DEPTH
//  stream_ready   in   1                      consumer accepts beat
//  stream_data    out  ARRAY_SIZE*ACT_BITS    beat data
//  stream_valid   out  1                      beat present
//  stream_last    out  1                      final beat marker, qualified by valid
//  stream_done    out  1                      one-cycle pulse after last beat accepted
//  busy           out  1                      state != IDLE
//  rd_bank        out  clog2(NUM_BANKS)       current read bank
//  start_err      out  1                      pulse: stream_start while busy (ignored)
// BEHAVIOUR
//  Reset: all outputs 0, rd_bank=0, state IDLE, output FIFO empty, swap_pending=0. Bank contents undefined.
//  Fill bank = (rd_bank+1) mod NUM_BANKS; writes never touch rd_bank; same-cycle write/read always legal.
//  swap_banks in IDLE: rd_bank advances next cycle (wraps NUM_BANKS-1 -> 0).
//  swap_banks while busy: sets swap_pending; applied in the cycle stream_done pulses.
//  FSM IDLE -> ISSUE on stream_start; count==0 goes IDLE -> DONE, no beats.
//  ISSUE: issue one read/cycle while issued-not-accepted < 2; addr = base + i*stride mod DEPTH (wraps).
//  ISSUE -> DRAIN after count reads; DRAIN -> DONE when FIFO empty and last accepted; DONE -> IDLE (1 cycle).
//  Read latency 1 cycle into 2-entry output FIFO; first valid 2 cycles after start with ready high.
//  Full throughput: 1 beat/cycle with stream_ready held high.
//  Handshake: data/last held stable while valid && !ready; beat transfers on valid && ready.
//  stream_last on beat count-1 only; stream_done the cycle after that beat transfers.
//  Reset mid-stream: immediate return to IDLE, FIFO flushed, pending swap dropped.
// CONFIGURATION
//  TPU_ACT_SKEW_EN defined: lane j delayed j beats via per-lane shift regs (zero-filled) for systolic wavefront.
//    Stream lasts count+ARRAY_SIZE-1 beats; last/done after flush beat; shift regs advance only on valid&&ready.
//  Undefined: all lanes aligned, count beats exactly, no skew registers.
// STRUCTURE
//  Package tpu_act_pkg: stream_state_t {S_IDLE,S_ISSUE,S_DRAIN,S_DONE}, act_vec_t typedef,
//  localparams for index widths (clog2 DEPTH/NUM_BANKS).
//  Sub-module tpu_act_out_fifo: 2-entry vector FIFO with valid/ready and last bit; rest inline.
// TESTING
//  Write 0..7 to fill, swap, start base=0 stride=1 count=8 ready=1 -> vectors 0..7 in 8 consecutive cycles, last on 7th index, done next.
//  base=250 stride=3 count=4, DEPTH=256 -> indices 250,253,0,3 (wrap).
//  ready toggled 1/0 every cycle -> no beat lost/duplicated; data stable across stalls.
//  swap mid-stream, NUM_BANKS=3 -> rd_bank unchanged until done, then 0->1; swap at rd_bank=2 -> 0.
//  count=0 -> no valid, done pulse 1 cycle after start; start while busy -> start_err, stream unaffected.
//  SKEW_EN, ARRAY_SIZE=4, count=2 -> lane3 sees 0,0,0,v0,v1 over 5 beats; rst_n low mid-stream -> valid=0 immediately.

Source files
------------

// File: rtl/tpu_act_pkg.sv
// Shared types and default sizes for the activation stream buffer.
package tpu_act_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } stream_state_t;

  localparam int ARRAY_SIZE_DEF = 8;
  localparam int ACT_BITS_DEF   = 16;
  localparam int DEPTH_DEF      = 256;
  localparam int NUM_BANKS_DEF  = 2;
  localparam int ADDR_WIDTH_DEF = 16;
  localparam int IDX_W_DEF      = $clog2(DEPTH_DEF);
  localparam int BANK_W_DEF     = $clog2(NUM_BANKS_DEF);

  typedef logic [ARRAY_SIZE_DEF*ACT_BITS_DEF-1:0] act_vec_t;

endpackage

// File: rtl/tpu_act_out_fifo.sv
// Two-entry vector FIFO carrying a last-beat flag; pops on out_valid && out_ready.
module tpu_act_out_fifo #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         full
);

  logic [W:0] ent_q [2];
  logic [W:0] ent_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       push_ok, pop;

  assign out_valid = (cnt_q != 2'd0);
  assign full      = (cnt_q == 2'd2);
  assign pop       = out_valid && out_ready;
  assign push_ok   = push && !full;
  assign {out_last, out_data} = ent_q[rd_ptr_q];

  always_comb begin
    ent_d = ent_q;
    if (push_ok) ent_d[wr_ptr_q] = {push_last, push_data};
    wr_ptr_d = wr_ptr_q ^ push_ok;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push_ok} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      ent_q    <= ent_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/tpu_act_stream_buffer.sv
// Ring of activation banks streaming strided vectors to the array over valid/ready.
// Define TPU_ACT_SKEW_EN to delay lane j by j beats (zero-filled systolic wavefront).
module tpu_act_stream_buffer
  import tpu_act_pkg::*;
#(
  parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
  parameter int ACT_BITS   = ACT_BITS_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int NUM_BANKS  = NUM_BANKS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           swap_banks,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [ARRAY_SIZE*ACT_BITS-1:0] wr_data,
  output logic                           wr_err,
  input  logic                           stream_start,
  input  logic [$clog2(DEPTH)-1:0]       stream_base,
  input  logic [$clog2(DEPTH)-1:0]       stream_stride,
  input  logic [$clog2(DEPTH):0]         stream_count,
  input  logic                           stream_ready,
  output logic [ARRAY_SIZE*ACT_BITS-1:0] stream_data,
  output logic                           stream_valid,
  output logic                           stream_last,
  output logic                           stream_done,
  output logic                           busy,
  output logic [$clog2(NUM_BANKS)-1:0]   rd_bank,
  output logic                           start_err
);

  localparam int VW = ARRAY_SIZE * ACT_BITS;
  localparam int IW = $clog2(DEPTH);
  localparam int BW = $clog2(NUM_BANKS);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [BW-1:0]       LAST_BANK = BW'(NUM_BANKS - 1);
  localparam logic [IW:0]         ONE_BEAT  = (IW+1)'(1);

  stream_state_t  state_q, state_d;
  logic [BW-1:0]  rd_bank_q, rd_bank_d;
  logic           swap_pend_q, swap_pend_d;
  logic [IW-1:0]  addr_q, addr_d;
  logic [IW-1:0]  stride_q, stride_d;
  logic [IW:0]    cnt_q, cnt_d;
  logic [IW:0]    iss_q, iss_d;
  logic           wr_err_q, wr_err_d;
  logic           start_err_q, start_err_d;

  logic [VW-1:0]  bank_mem [NUM_BANKS][DEPTH];
  logic [BW-1:0]  fill_bank;
  logic           wr_ok, issue, issue_last, beat_acc;
  logic           fifo_full, fifo_valid, fifo_last;
  logic [VW-1:0]  fifo_data;

  assign fill_bank = (rd_bank_q == LAST_BANK) ? '0 : rd_bank_q + BW'(1);
  assign wr_ok     = wr_en && ({1'b0, wr_addr} < DEPTH_LIM);

  // Only the fill bank is writable, so reads of rd_bank never race a write.
  always_ff @(posedge clk) begin
    if (wr_ok) bank_mem[fill_bank][wr_addr[IW-1:0]] <= wr_data;
  end

  // At most two reads are outstanding: the FIFO itself is the read register.
  assign issue      = (state_q == S_ISSUE) && !fifo_full;
  assign issue_last = (iss_q == cnt_q - ONE_BEAT);

  tpu_act_out_fifo #(.W(VW)) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (issue),
    .push_data (bank_mem[rd_bank_q][addr_q]),
    .push_last (issue_last),
    .out_ready (stream_ready),
    .out_valid (fifo_valid),
    .out_data  (fifo_data),
    .out_last  (fifo_last),
    .full      (fifo_full)
  );

  // Handshake: a beat moves on stream_valid && stream_ready; while valid is high
  // and ready is low, stream_data and stream_last hold their values.
  assign beat_acc = stream_valid && stream_ready;

`ifdef TPU_ACT_SKEW_EN
  localparam int OCW = $clog2(DEPTH + ARRAY_SIZE) + 1;

  logic [VW-1:0]  hist_q [ARRAY_SIZE-1];
  logic [VW-1:0]  hist_d [ARRAY_SIZE-1];
  logic [VW-1:0]  src_vec;
  logic [OCW-1:0] out_cnt_q, out_cnt_d, cnt_ext;
  logic           data_phase;

  assign cnt_ext      = OCW'(cnt_q);
  assign data_phase   = (out_cnt_q < cnt_ext);
  assign src_vec      = data_phase ? fifo_data : '0;
  assign stream_valid = data_phase ? fifo_valid : (state_q == S_DRAIN);
  assign stream_last  = stream_valid && (out_cnt_q == cnt_ext + OCW'(ARRAY_SIZE - 2));

  always_comb begin
    stream_data = '0;
    stream_data[ACT_BITS-1:0] = src_vec[ACT_BITS-1:0];
    for (int j = 1; j < ARRAY_SIZE; j++)
      stream_data[j*ACT_BITS +: ACT_BITS] = hist_q[j-1][j*ACT_BITS +: ACT_BITS];
  end

  // History shifts only on accepted beats so stalls never smear the wavefront.
  always_comb begin
    hist_d    = hist_q;
    out_cnt_d = out_cnt_q;
    if (state_q == S_IDLE && stream_start) begin
      for (int i = 0; i < ARRAY_SIZE-1; i++) hist_d[i] = '0;
      out_cnt_d = '0;
    end else if (beat_acc) begin
      hist_d[0] = src_vec;
      for (int i = 1; i < ARRAY_SIZE-1; i++) hist_d[i] = hist_q[i-1];
      out_cnt_d = out_cnt_q + OCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARRAY_SIZE-1; i++) hist_q[i] <= '0;
      out_cnt_q <= '0;
    end else begin
      hist_q    <= hist_d;
      out_cnt_q <= out_cnt_d;
    end
  end
`else
  assign stream_valid = fifo_valid;
  assign stream_last  = fifo_valid && fifo_last;
  assign stream_data  = fifo_data;
`endif

  always_comb begin
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    swap_pend_d = swap_pend_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    cnt_d       = cnt_q;
    iss_d       = iss_q;
    wr_err_d    = wr_en && !wr_ok;
    start_err_d = stream_start && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (swap_banks) rd_bank_d = fill_bank;
        if (stream_start) begin
          addr_d   = stream_base;
          stride_d = stream_stride;
          cnt_d    = stream_count;
          iss_d    = '0;
          state_d  = (stream_count == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (swap_banks) swap_pend_d = 1'b1;
        if (issue) begin
          addr_d = addr_q + stride_q;
          iss_d  = iss_q + ONE_BEAT;
          if (issue_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (swap_banks) swap_pend_d = 1'b1;
        if (beat_acc && stream_last) state_d = S_DONE;
      end
      S_DONE: begin
        if (swap_pend_q || swap_banks) rd_bank_d = fill_bank;
        swap_pend_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_bank_q   <= '0;
      swap_pend_q <= 1'b0;
      addr_q      <= '0;
      stride_q    <= '0;
      cnt_q       <= '0;
      iss_q       <= '0;
      wr_err_q    <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      swap_pend_q <= swap_pend_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      cnt_q       <= cnt_d;
      iss_q       <= iss_d;
      wr_err_q    <= wr_err_d;
      start_err_q <= start_err_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign stream_done = (state_q == S_DONE);
  assign rd_bank     = rd_bank_q;
  assign wr_err      = wr_err_q;
  assign start_err   = start_err_q;

endmodule

// File: tb/tb_tpu_act_stream_buffer.sv
// Scoreboard bench for tpu_act_stream_buffer with a three-bank ring and 256-deep banks.
module tb_tpu_act_stream_buffer;
  import tpu_act_pkg::*;

  localparam int AS  = ARRAY_SIZE_DEF;
  localparam int AB  = ACT_BITS_DEF;
  localparam int DEP = DEPTH_DEF;
  localparam int NB  = 3;
  localparam int AW  = ADDR_WIDTH_DEF;
  localparam int VW  = AS * AB;
  localparam int IW  = IDX_W_DEF;

  logic          clk, rst_n;
  logic          swap_banks, wr_en, wr_err;
  logic [AW-1:0] wr_addr;
  act_vec_t      wr_data, stream_data;
  logic          stream_start, stream_ready, stream_valid, stream_last, stream_done;
  logic [IW-1:0] stream_base, stream_stride;
  logic [IW:0]   stream_count;
  logic          busy, start_err;
  logic [1:0]    rd_bank;

  tpu_act_stream_buffer #(
    .ARRAY_SIZE(AS), .ACT_BITS(AB), .DEPTH(DEP), .NUM_BANKS(NB), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .swap_banks(swap_banks),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .stream_start(stream_start), .stream_base(stream_base), .stream_stride(stream_stride),
    .stream_count(stream_count), .stream_ready(stream_ready), .stream_data(stream_data),
    .stream_valid(stream_valid), .stream_last(stream_last), .stream_done(stream_done),
    .busy(busy), .rd_bank(rd_bank), .start_err(start_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [VW:0]   exp_q[$];
  logic [VW-1:0] model_mem [NB][DEP];
  int            m_bank;
  int            n_checks, n_errors;
  logic          have_hold;
  logic [VW:0]   hold_val, got, want;

  task automatic chk(input string nm, input logic [VW:0] act, input logic [VW:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic act_vec_t mk_vec(input int b, input int i);
    act_vec_t v;
    for (int j = 0; j < AS; j++) v[j*AB +: AB] = 16'(b*4096 + i*8 + j);
    return v;
  endfunction

  function automatic int done_lat(input int count);
`ifdef TPU_ACT_SKEW_EN
    return (count == 0) ? 1 : count + AS + 1;
`else
    return (count == 0) ? 1 : count + 2;
`endif
  endfunction

  task automatic push_expected(input int base, input int stride, input int count);
    logic [VW-1:0] src[$];
    int total;
    for (int i = 0; i < count; i++) src.push_back(model_mem[m_bank][(base + i*stride) % DEP]);
`ifdef TPU_ACT_SKEW_EN
    total = (count == 0) ? 0 : count + AS - 1;
    for (int k = 0; k < total; k++) begin
      logic [VW-1:0] v;
      v = '0;
      for (int j = 0; j < AS; j++)
        if (k - j >= 0 && k - j < count) v[j*AB +: AB] = src[k-j][j*AB +: AB];
      exp_q.push_back({(k == total - 1), v});
    end
`else
    total = count;
    for (int k = 0; k < total; k++) exp_q.push_back({(k == total - 1), src[k]});
`endif
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      have_hold = 1'b0;
    end else begin
      got = {stream_last, stream_data};
      if (have_hold) chk("stall_hold", {stream_valid, got}, {1'b1, hold_val});
      if (stream_valid && stream_ready) begin
        have_hold = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", got, '0);
          if (got == '0) chk_int("unexpected_beat_zero", 1, 0);
        end else begin
          want = exp_q.pop_front();
          chk("beat", got, want);
        end
      end else if (stream_valid) begin
        have_hold = 1'b1;
        hold_val  = got;
      end else begin
        have_hold = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_write(input int addr, input act_vec_t d);
    wr_en   = 1'b1;
    wr_addr = 16'(addr);
    wr_data = d;
    if (addr < DEP) model_mem[(m_bank + 1) % NB][addr] = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic swap_idle(input string nm);
    swap_banks = 1'b1;
    @(posedge clk); #1;
    swap_banks = 1'b0;
    m_bank = (m_bank + 1) % NB;
    @(negedge clk);
    chk_int(nm, int'(rd_bank), m_bank);
    @(posedge clk); #1;
  endtask

  task automatic run_stream(input int base, input int stride, input int count, input bit toggle,
                            input int exp_done, input int swap_at, input int busy_at,
                            input string nm);
    int cyc, first_v, done_cyc, bank0;
    bit serr_seen, bank_moved;
    push_expected(base, stride, count);
    bank0         = m_bank;
    stream_base   = 8'(base);
    stream_stride = 8'(stride);
    stream_count  = 9'(count);
    stream_start  = 1'b1;
    stream_ready  = 1'b1;
    @(posedge clk); #1;
    stream_start = 1'b0;
    cyc = 0; first_v = -1; done_cyc = -1; serr_seen = 0; bank_moved = 0;
    while (cyc < 400 && done_cyc < 0) begin
      cyc++;
      stream_ready = toggle ? cyc[0] : 1'b1;
      swap_banks   = (cyc == swap_at);
      stream_start = (cyc == busy_at);
      if (cyc == busy_at) begin
        stream_base  = 8'd77;
        stream_count = 9'd3;
      end
      @(negedge clk);
      if (stream_valid && first_v < 0) first_v = cyc;
      if (start_err) serr_seen = 1;
      if (int'(rd_bank) != bank0) bank_moved = 1;
      if (stream_done) done_cyc = cyc;
      @(posedge clk); #1;
    end
    swap_banks = 1'b0; stream_start = 1'b0; stream_ready = 1'b1;
    chk_int({nm, "_done_seen"}, int'(done_cyc >= 0), 1);
    if (exp_done > 0) chk_int({nm, "_done_cycle"}, done_cyc, exp_done);
    chk_int({nm, "_first_valid"}, first_v, (count == 0) ? -1 : 2);
    chk_int({nm, "_start_err"}, int'(serr_seen), int'(busy_at > 0));
    chk_int({nm, "_bank_held"}, int'(bank_moved), 0);
    if (swap_at > 0) m_bank = (m_bank + 1) % NB;
    @(negedge clk);
    chk_int({nm, "_rd_bank_after"}, int'(rd_bank), m_bank);
    chk_int({nm, "_idle_after"}, int'(busy), 0);
    chk_int({nm, "_all_beats"}, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_errors = 0; m_bank = 0; have_hold = 1'b0;
    swap_banks = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    stream_start = 0; stream_base = '0; stream_stride = '0; stream_count = '0;
    stream_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_int("rst_valid", int'(stream_valid), 0);
    chk_int("rst_busy", int'(busy), 0);
    chk_int("rst_rd_bank", int'(rd_bank), 0);
    chk_int("rst_done", int'(stream_done), 0);
    chk_int("rst_last", int'(stream_last), 0);
    chk_int("rst_errs", int'({wr_err, start_err}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < DEP; i++) do_write(i, mk_vec(1, i));
    @(negedge clk);
    chk_int("wr_err_ok", int'(wr_err), 0);
    @(posedge clk); #1;
    do_write(259, mk_vec(7, 7));
    @(negedge clk);
    chk_int("wr_err_pulse", int'(wr_err), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk_int("wr_err_clear", int'(wr_err), 0);
    @(posedge clk); #1;

    swap_idle("swap_0_to_1");
    run_stream(0, 1, 8, 0, done_lat(8), 0, 0, "seq8");
    run_stream(250, 3, 4, 0, done_lat(4), 0, 0, "wrap");
    run_stream(5, 1, 12, 1, -1, 0, 0, "toggle");
    run_stream(0, 1, 0, 0, done_lat(0), 0, 0, "cnt0");

    for (int i = 0; i < 16; i++) do_write(i, mk_vec(2, i));
    run_stream(16, 2, 8, 0, done_lat(8), 3, 4, "swap_busy");
    run_stream(0, 1, 6, 1, -1, 0, 0, "bank2");

    for (int i = 0; i < 16; i++) do_write(i, mk_vec(0, i));
    swap_idle("swap_2_to_0");
    run_stream(3, 5, 3, 0, done_lat(3), 0, 0, "bank0");
    swap_idle("swap_0_to_1b");

    // Reset in the middle of a long stream from bank 1.
    push_expected(0, 1, 16);
    stream_base = '0; stream_stride = 8'd1; stream_count = 9'd16;
    stream_start = 1'b1;
    @(posedge clk); #1;
    stream_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_int("midrst_valid", int'(stream_valid), 0);
    chk_int("midrst_busy", int'(busy), 0);
    chk_int("midrst_rd_bank", int'(rd_bank), 0);
    exp_q.delete();
    m_bank = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_int("postrst_valid", int'(stream_valid), 0);
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) do_write(i, mk_vec(5, i));
    swap_idle("postrst_swap");
    run_stream(0, 1, 4, 0, done_lat(4), 0, 0, "postrst");

    repeat (3) @(posedge clk);
    chk_int("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
